// File: rtl/dup_range_gen.sv
// Signed range stream generator: for i = base; i < limit; i += step, emit i REPEAT times.
// Start/done control on the input side, valid/ready stream on the output side.
module dup_range_gen #(
    parameter int WIDTH  = 32,
    parameter int REPEAT = 2
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic                    _start,
    input  logic                    _ready,
    input  logic signed [WIDTH-1:0] base,
    input  logic signed [WIDTH-1:0] limit,
    input  logic signed [WIDTH-1:0] step,
    output logic                    _done,
    output logic                    _valid,
    output logic signed [WIDTH-1:0] _out0
);

    // state | meaning
    // IDLE  | out of reset, waiting for _start
    // EMIT  | streaming beats of element i, rep counts beats already sent
    // DONE  | sequence finished, _done held until next accepted _start
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    localparam logic [3:0] REP_LAST = 4'(REPEAT - 1);

    state_t                  state;
    logic signed [WIDTH-1:0] i_reg;
    logic signed [WIDTH-1:0] limit_reg;
    logic signed [WIDTH-1:0] step_reg;
    logic        [3:0]       rep;

    // One extra bit so i+step can never wrap into a value below limit.
    logic signed [WIDTH:0] next_sum;
    logic signed [WIDTH:0] limit_ext;
    logic                  start_empty;

    assign next_sum    = $signed({i_reg[WIDTH-1], i_reg}) + $signed({step_reg[WIDTH-1], step_reg});
    assign limit_ext   = $signed({limit_reg[WIDTH-1], limit_reg});
    assign start_empty = step[WIDTH-1] || (step == '0) || (base >= limit);

    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            state     <= IDLE;
            i_reg     <= '0;
            limit_reg <= '0;
            step_reg  <= '0;
            rep       <= '0;
            _valid    <= 1'b0;
            _done     <= 1'b0;
            _out0     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (_start) begin
                        limit_reg <= limit;
                        step_reg  <= step;
                        i_reg     <= base;
                        rep       <= '0;
                        if (start_empty) begin
                            state  <= DONE;
                            _valid <= 1'b0;
                            _done  <= 1'b1;
                        end else begin
                            state  <= EMIT;
                            _valid <= 1'b1;
                            _done  <= 1'b0;
                            _out0  <= base;
                        end
                    end
                end
                EMIT: begin
                    if (_ready) begin
                        if (rep == REP_LAST) begin
                            rep <= '0;
                            if (next_sum < limit_ext) begin
                                i_reg <= next_sum[WIDTH-1:0];
                                _out0 <= next_sum[WIDTH-1:0];
                            end else begin
                                state  <= DONE;
                                _valid <= 1'b0;
                                _done  <= 1'b1;
                            end
                        end else begin
                            rep <= rep + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dup_range_gen.sv
// Directed bench for dup_range_gen: instance a uses REPEAT=2, instance b uses REPEAT=1.
module tb_dup_range_gen;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start_a, start_b, ready_a, ready_b;
    logic signed [31:0] base, limit, step;
    logic               done_a, valid_a, done_b, valid_b;
    logic signed [31:0] out_a, out_b;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    dup_range_gen #(.WIDTH(32), .REPEAT(2)) dut_a (
        ._clock(clk), ._reset(rst_n), ._start(start_a), ._ready(ready_a),
        .base(base), .limit(limit), .step(step),
        ._done(done_a), ._valid(valid_a), ._out0(out_a)
    );

    dup_range_gen #(.WIDTH(32), .REPEAT(1)) dut_b (
        ._clock(clk), ._reset(rst_n), ._start(start_b), ._ready(ready_b),
        .base(base), .limit(limit), .step(step),
        ._done(done_b), ._valid(valid_b), ._out0(out_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where _done was observed.
    task automatic run(input bit sel, input logic signed [31:0] b, input logic signed [31:0] l,
                       input logic signed [31:0] s, input int stall_at, input int stall_len,
                       input string tag);
        int   c = 0;
        int   nb = 0;
        bit   seen_done = 0;
        bit   stalled_prev = 0;
        bit   rdy;
        logic [31:0] prev = '0;
        logic cv, cd;
        logic [31:0] co;
        base = b; limit = l; step = s;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        ready_a = 1'b1; ready_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        base = 32'sh5a5a_5a5a; limit = -32'sd1; step = 32'sd0;
        while (!seen_done && c < 200) begin
            rdy = !(c >= stall_at && c < stall_at + stall_len);
            ready_a = rdy; ready_b = rdy;
            cv = sel ? valid_b : valid_a;
            cd = sel ? done_b  : done_a;
            co = sel ? out_b   : out_a;
            if (c == 0) begin
                check({tag, "_first_valid"}, 64'(cv), 64'(exp_q.size() != 0));
                check({tag, "_first_done"},  64'(cd), 64'(exp_q.size() == 0));
            end
            if (stalled_prev) check({tag, "_hold"}, 64'(co), 64'(prev));
            if (cd) begin
                seen_done = 1;
                check({tag, "_done_cycle"}, 64'(c), 64'(exp_q.size() + stall_len));
                check({tag, "_done_valid"}, 64'(cv), 64'd0);
            end else begin
                if (cv && rdy) begin
                    if (nb < exp_q.size()) check({tag, "_beat"}, 64'(co), 64'(exp_q[nb]));
                    nb++;
                end
                stalled_prev = cv && !rdy;
                prev = co;
                c++;
                @(negedge clk);
            end
        end
        ready_a = 1'b1; ready_b = 1'b1;
        check({tag, "_finished"}, 64'(seen_done), 64'd1);
        check({tag, "_beat_count"}, 64'(nb), 64'(exp_q.size()));
    endtask

    task automatic hold_done(input bit sel, input string tag);
        repeat (3) begin
            @(negedge clk);
            check({tag, "_done_held"}, 64'(sel ? done_b : done_a), 64'd1);
            check({tag, "_valid_low"}, 64'(sel ? valid_b : valid_a), 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
        base = '0; limit = '0; step = '0;
        repeat (2) @(negedge clk);
        check("rst_valid_a", 64'(valid_a), 64'd0);
        check("rst_done_a",  64'(done_a),  64'd0);
        check("rst_out_a",   64'(out_a),   64'd0);
        check("rst_valid_b", 64'(valid_b), 64'd0);
        check("rst_done_b",  64'(done_b),  64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        exp_q = {0, 0, 2, 2, 4, 4, 6, 6, 8, 8};
        run(0, 0, 10, 2, 1000, 0, "basic");
        hold_done(0, "basic");

        exp_q = {1, 4, 7, 10};
        run(1, 1, 11, 3, 1000, 0, "rep1");
        exp_q = {0, 2, 4, 6, 8};
        run(1, 0, 10, 2, 1000, 0, "rep1_b2b");
        hold_done(1, "rep1_b2b");

        exp_q = {0, 0, 2, 2, 4, 4, 6, 6, 8, 8};
        run(0, 0, 10, 2, 3, 3, "bp");

        exp_q = {};
        run(0, 5, 5, 1, 1000, 0, "empty_eq");
        run(0, 7, 3, 1, 1000, 0, "empty_rev");
        run(0, 0, 10, 0, 1000, 0, "empty_step0");
        run(0, 0, 10, -1, 1000, 0, "empty_neg");
        hold_done(0, "empty");

        exp_q = {32'd2147483646, 32'd2147483646};
        run(0, 32'sd2147483646, 32'sd2147483647, 5, 1000, 0, "ovf");
        hold_done(0, "ovf");

        base = 0; limit = 10; step = 2; ready_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_valid_before", 64'(valid_a), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(valid_a), 64'd0);
        check("mid_rst_out",   64'(out_a),   64'd0);
        check("mid_rst_done",  64'(done_a),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_done",  64'(done_a),  64'd0);
        check("post_rst_valid", 64'(valid_a), 64'd0);
        exp_q = {0, 0, 1, 1, 2, 2, 3, 3};
        run(0, 0, 4, 1, 1000, 0, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
